dct2_1d_seq: RTL and testbench
==============================

# dct2_1d_seq

Row sequencer for the 1-D DCT-II datapath (butterfly stages plus output permutation, sizes 4/8/16/32). Accepts one block command (size code, row count), reads rows from the input line buffer one per cycle, and launches them into the fixed-latency, non-stallable datapath. Tracks in-flight rows and downstream buffer credits so that no result is ever dropped. Holds the size code stable for the whole pipeline, and flags first/last rows and block completion.

## Interface
Parameters:
- LAT, 4, datapath latency in cycles from dp_valid to result valid (1..16)
- DEPTH, 4, entries in the downstream result FIFO, which is also the initial credit count (1..32)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  block command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_n  in  2  size code: 0=4, 1=8, 2=16, 3=32 points
- cmd_rows_m1  in  5  rows in block minus one (1..32 rows)
- rd_en  out  1  input line-buffer read strobe; data returns next cycle
- rd_row  out  5  row index being read
- dp_valid  out  1  the datapath input this cycle is a real row
- dp_n  out  2  size code driven to butterflies and permutation
- out_valid  out  1  the datapath result this cycle is real; write it into the FIFO
- out_first  out  1  qualifies out_valid: row 0 of the block
- out_last  out  1  qualifies out_valid: final row of the block
- out_pop  in  1  downstream popped one FIFO entry; returns one credit
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the last result of a block leaves the datapath
- cred_err  out  1  sticky; set when out_pop arrives with credits == DEPTH

## Operation
- States:
  - IDLE: cmd_ready=1. On accept, latch n and rows_m1, clear the row counter, and go to RUN.
  - RUN: issue a read when credits != 0. Issue means rd_en=1, rd_row=counter, and the counter increments. Issuing row rows_m1 moves the FSM to DRAIN.
  - DRAIN: wait until the in-flight pipe is empty, then go to IDLE.
- Credits: 6-bit counter, reset to DEPTH.
  - Issue decrements it; out_pop increments it.
  - Issue and pop in the same cycle leave it unchanged.
  - The issue decision uses the registered count, so a pop becomes visible to issue on the next cycle.
  - A pop at DEPTH is ignored (count saturates) and sets cred_err.
- In-flight pipe: LAT+1 stage shift register of {valid, first, last}. It covers one cycle of read latency plus LAT.
  - dp_valid = stage 0 valid.
  - out_valid / out_first / out_last = final stage.
- dp_n is driven from the latched n and changes only in IDLE. A block's rows therefore never see a size change.
- done = out_valid && out_last.

## Timing
- Reset values:
  - Outputs: cmd_ready=1, rd_en=0, rd_row=0, dp_valid=0, dp_n=0, out_valid=0, out_first=0, out_last=0, busy=0, done=0, cred_err=0.
  - Internal: credits=DEPTH; pipe cleared.
- Command accepted at cycle t: first rd_en at t+1.
- rd_en at cycle c: dp_valid at c+1 and out_valid at c+1+LAT.
- With full credits and continuous pops, a block of R rows issues on R consecutive cycles. done is asserted at t+R+1+LAT.
- Last out_valid of the block: the FSM returns to IDLE on the same edge, so cmd_ready is 1 on the following cycle.
- Reset mid-block: rst applied during RUN or DRAIN takes effect at that edge. The pipe is flushed, credits restored, and in-flight results are discarded without out_valid.
- Single-row block (rows_m1=0): one issue with first=last=1; RUN goes directly to DRAIN.

## Configuration
- DCT_SEQ_BACK2BACK_EN
- Defined:
  - cmd_ready is also 1 in DRAIN when cmd_n equals the latched n.
  - An accepted command goes straight to RUN, and its first rd_en can immediately follow the previous block's last rd_en.
  - A command with a different n waits for the drain to finish.
- Undefined: cmd_ready=1 only in IDLE. Every block fully drains before the next is accepted.

## Test plan
- Basic: LAT=4, DEPTH=4, out_pop=1 every cycle, cmd n=0 rows_m1=3 at t=0.
  - rd_en at t=1..4 with rd_row=0..3.
  - out_valid at t=6..9; out_first at t=6; out_last and done at t=9; busy low at t=10.
- Credit stall: DEPTH=4, n=3 rows_m1=7, no pops.
  - Exactly 4 rd_en are issued, then none.
  - A single pop at cycle p gives exactly one more rd_en at p+1.
  - The total out_valid count is never more than 4 plus the number of pops.
- Simultaneous issue+pop: credits at 1 with a pop every cycle.
  - Issue continues every cycle; the credit counter stays at 1.
- Reset mid-block: rst during RUN after 2 of 8 rows.
  - The next cycle shows all reset values, and no out_valid follows.
  - A new command completes normally.
- Back-to-back (macro defined): two n=1 blocks with rows_m1=1 each.
  - rd_en on 4 consecutive cycles; two done pulses 2 cycles apart.
  - A third command with n=2 waits for the second done; it is accepted on the cycle after the second block's last out_valid.
- Overflow: out_pop with credits=DEPTH and no issue.
  - cred_err rises next cycle and stays high until rst; credits stay at DEPTH.

Source files
------------

// File: rtl/dct2_1d_seq_if.sv
// rtl/dct2_1d_seq_if.sv - command, line-buffer, datapath and result-FIFO signals of the DCT row sequencer
interface dct2_1d_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_n;
    logic [4:0] cmd_rows_m1;
    logic       rd_en;
    logic [4:0] rd_row;
    logic       dp_valid;
    logic [1:0] dp_n;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic       out_pop;
    logic       busy;
    logic       done;
    logic       cred_err;

    // Environment side: offers commands and returns FIFO credits
    modport master (
        output cmd_valid, cmd_n, cmd_rows_m1, out_pop,
        input  cmd_ready, rd_en, rd_row, dp_valid, dp_n,
        input  out_valid, out_first, out_last, busy, done, cred_err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_n, cmd_rows_m1, out_pop,
        output cmd_ready, rd_en, rd_row, dp_valid, dp_n,
        output out_valid, out_first, out_last, busy, done, cred_err
    );
endinterface

// File: rtl/dct2_1d_seq.sv
// rtl/dct2_1d_seq.sv - row sequencer for the 1-D DCT-II datapath (optional DCT_SEQ_BACK2BACK_EN)
module dct2_1d_seq #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    dct2_1d_seq_if.slave       bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [5:0] CRED_MAX = 6'(DEPTH);

    state_t       r_state;
    logic [1:0]   r_n;
    logic [4:0]   r_rows_m1;
    logic [4:0]   r_cnt;
    logic [5:0]   r_credits;
    logic         r_cred_err;
    // In-flight tracking: stage 0 is the row coming back from the line buffer,
    // stage LAT is the result leaving the datapath.
    logic [LAT:0] r_pv;
    logic [LAT:0] r_pf;
    logic [LAT:0] r_pl;

    logic w_issue;
    logic w_last_issue;
    logic w_first_issue;
    logic w_pipe_busy;
    logic w_pop_ok;
    logic w_pop_over;
    logic w_cmd_ready;
    logic w_accept;

    // Issue only on registered credits, so a pop is seen one cycle later
    assign w_issue       = (r_state == S_RUN) && (r_credits != 6'd0);
    assign w_last_issue  = w_issue && (r_cnt == r_rows_m1);
    assign w_first_issue = w_issue && (r_cnt == 5'd0);
    // Everything before the last stage; a result in the last stage leaves on this edge
    assign w_pipe_busy   = |r_pv[LAT-1:0];
    assign w_pop_ok      = bus.out_pop && (r_credits != CRED_MAX);
    assign w_pop_over    = bus.out_pop && (r_credits == CRED_MAX);

`ifdef DCT_SEQ_BACK2BACK_EN
    // A same-size block may chain onto the one still in flight, starting on the
    // cycle of the previous block's final issue so reads stay contiguous.
    assign w_cmd_ready = (r_state == S_IDLE) ||
                         ((bus.cmd_n == r_n) && ((r_state == S_DRAIN) || w_last_issue));
`else
    assign w_cmd_ready = (r_state == S_IDLE);
`endif

    assign w_accept = bus.cmd_valid && w_cmd_ready;

    // Block FSM: command latch, row counter and state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_n       <= 2'd0;
            r_rows_m1 <= 5'd0;
            r_cnt     <= 5'd0;
        end else if (w_accept) begin
            r_state   <= S_RUN;
            r_n       <= bus.cmd_n;
            r_rows_m1 <= bus.cmd_rows_m1;
            r_cnt     <= 5'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_issue) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Credit counter: issue consumes, pop returns, pop at full is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CRED_MAX;
        end else begin
            r_credits <= r_credits - 6'(w_issue) + 6'(w_pop_ok);
        end
    end

    // Sticky flag for a pop that had no credit to return
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cred_err <= 1'b0;
        end else if (w_pop_over) begin
            r_cred_err <= 1'b1;
        end
    end

    // In-flight shift register of {valid, first, last}; flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
            r_pf <= '0;
            r_pl <= '0;
        end else begin
            r_pv <= {r_pv[LAT-1:0], w_issue};
            r_pf <= {r_pf[LAT-1:0], w_first_issue};
            r_pl <= {r_pl[LAT-1:0], w_last_issue};
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rd_en     = w_issue;
    assign bus.rd_row    = w_issue ? r_cnt : 5'd0;
    assign bus.dp_valid  = r_pv[0];
    assign bus.dp_n      = r_n;
    assign bus.out_valid = r_pv[LAT];
    assign bus.out_first = r_pf[LAT];
    assign bus.out_last  = r_pl[LAT];
    assign bus.done      = r_pv[LAT] && r_pl[LAT];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.cred_err  = r_cred_err;

endmodule

// File: tb/tb_dct2_1d_seq.sv
// tb/tb_dct2_1d_seq.sv - directed self-checking bench for dct2_1d_seq (LAT=4, DEPTH=4)
module tb_dct2_1d_seq;
    logic clk;
    logic rst;
    dct2_1d_seq_if bus ();

    dct2_1d_seq #(.LAT(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int occ;
    int n_pop;
    int n_ov;
    bit auto_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Consumer model: results land in a FIFO of occ entries and are popped one per cycle
    task automatic advance();
        n_ov  += int'(bus.out_valid);
        n_pop += int'(bus.out_pop);
        occ   += int'(bus.out_valid);
        if (bus.out_pop && occ > 0) occ--;
        @(posedge clk);
        #1;
        if (auto_pop) bus.out_pop = (occ > 0);
    endtask

    initial begin
        int rd_cnt;
        int ov_after;
        bit viol;
        total = 0; bad = 0; occ = 0; n_pop = 0; n_ov = 0; auto_pop = 1'b1;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_n = 2'd0; bus.cmd_rows_m1 = 5'd0; bus.out_pop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic 4-row block, n=0
        bus.cmd_valid = 1'b1; bus.cmd_n = 2'd0; bus.cmd_rows_m1 = 5'd3;
        for (int t = 0; t <= 11; t++) begin
            sample();
            if (t == 0) begin
                chk("rst.cmd_ready", bus.cmd_ready, 1);
                chk("rst.rd_row", bus.rd_row, 0);
                chk("rst.dp_n", bus.dp_n, 0);
                chk("rst.cred_err", bus.cred_err, 0);
                chk("rst.credits", dut.r_credits, 4);
            end
            chk($sformatf("p1.rd_en t=%0d", t), bus.rd_en, (t >= 1 && t <= 4));
            if (t >= 1 && t <= 4) chk($sformatf("p1.rd_row t=%0d", t), bus.rd_row, t - 1);
            chk($sformatf("p1.dp_valid t=%0d", t), bus.dp_valid, (t >= 2 && t <= 5));
            chk($sformatf("p1.out_valid t=%0d", t), bus.out_valid, (t >= 6 && t <= 9));
            chk($sformatf("p1.out_first t=%0d", t), bus.out_first, (t == 6));
            chk($sformatf("p1.out_last t=%0d", t), bus.out_last, (t == 9));
            chk($sformatf("p1.done t=%0d", t), bus.done, (t == 9));
            chk($sformatf("p1.busy t=%0d", t), bus.busy, (t >= 1 && t <= 9));
            advance();
            bus.cmd_valid = 1'b0;
        end

        // Credit stall, single pop, then issue with simultaneous pops at credits=1
        auto_pop = 1'b0; bus.out_pop = 1'b0; n_pop = 0; n_ov = 0; rd_cnt = 0; viol = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_n = 2'd3; bus.cmd_rows_m1 = 5'd7;
        for (int t = 0; t <= 26; t++) begin
            if (t <= 19) bus.out_pop = (t == 13) || (t >= 15 && t <= 17);
            if (t == 19) auto_pop = 1'b1;
            sample();
            rd_cnt += int'(bus.rd_en);
            if (n_ov + int'(bus.out_valid) > 4 + n_pop + int'(bus.out_pop)) viol = 1'b1;
            if (t == 10) chk("p2.dp_n", bus.dp_n, 3);
            if (t == 13) chk("p2.stall_issues", rd_cnt, 4);
            if (t == 14) begin
                chk("p2.pop_rd_en", bus.rd_en, 1);
                chk("p2.pop_rd_row", bus.rd_row, 4);
            end
            if (t == 15) chk("p2.one_more_only", bus.rd_en, 0);
            if (t >= 16 && t <= 18) begin
                chk($sformatf("p2.sim_rd_en t=%0d", t), bus.rd_en, 1);
                chk($sformatf("p2.sim_rd_row t=%0d", t), bus.rd_row, t - 11);
                chk($sformatf("p2.sim_credits t=%0d", t), dut.r_credits, 1);
            end
            if (t == 23) begin
                chk("p2.done", bus.done, 1);
                chk("p2.out_last", bus.out_last, 1);
            end
            if (t == 24) chk("p2.busy_low", bus.busy, 0);
            if (t == 26) begin
                chk("p2.total_out", n_ov, 8);
                chk("p2.ov_bound", viol, 0);
                chk("p2.credits_back", dut.r_credits, 4);
                chk("p2.cred_err", bus.cred_err, 0);
            end
            advance();
            bus.cmd_valid = 1'b0;
        end

        // Reset after two issued rows, then a fresh 2-row block
        ov_after = 0;
        bus.cmd_valid = 1'b1; bus.cmd_n = 2'd2; bus.cmd_rows_m1 = 5'd7;
        for (int t = 0; t <= 23; t++) begin
            if (t == 2) rst = 1'b1;
            if (t == 3) rst = 1'b0;
            if (t == 13) begin
                bus.cmd_valid = 1'b1; bus.cmd_n = 2'd1; bus.cmd_rows_m1 = 5'd1;
            end
            sample();
            if (t == 2) chk("p3.pre_rst_row", bus.rd_row, 1);
            if (t == 3) begin
                chk("p3.cmd_ready", bus.cmd_ready, 1);
                chk("p3.rd_en", bus.rd_en, 0);
                chk("p3.dp_valid", bus.dp_valid, 0);
                chk("p3.dp_n", bus.dp_n, 0);
                chk("p3.busy", bus.busy, 0);
                chk("p3.credits", dut.r_credits, 4);
            end
            if (t >= 3 && t <= 12) ov_after += int'(bus.out_valid);
            if (t == 12) chk("p3.no_out_after_rst", ov_after, 0);
            if (t == 14) begin
                chk("p3.new_rd_en", bus.rd_en, 1);
                chk("p3.new_dp_n", bus.dp_n, 1);
            end
            if (t == 15) chk("p3.new_rd_row", bus.rd_row, 1);
`ifdef DCT_SEQ_BACK2BACK_EN
            if (t == 16) chk("p3.drain_ready", bus.cmd_ready, 1);
`else
            if (t == 16) chk("p3.drain_ready", bus.cmd_ready, 0);
`endif
            if (t == 19) chk("p3.out_first", bus.out_first, 1);
            if (t == 20) begin
                chk("p3.done", bus.done, 1);
                chk("p3.first_not_last", bus.out_first, 0);
            end
            if (t == 21) chk("p3.busy_low", bus.busy, 0);
            advance();
            bus.cmd_valid = 1'b0;
        end

`ifdef DCT_SEQ_BACK2BACK_EN
        // Two chained n=1 blocks, then an n=2 command that must wait for the drain
        bus.cmd_valid = 1'b1; bus.cmd_n = 2'd1; bus.cmd_rows_m1 = 5'd1;
        for (int t = 0; t <= 17; t++) begin
            if (t == 3) begin
                bus.cmd_n = 2'd2; bus.cmd_rows_m1 = 5'd0;
            end
            if (t == 11) bus.cmd_valid = 1'b0;
            sample();
            if (t >= 1 && t <= 4) begin
                chk($sformatf("b2b.rd_en t=%0d", t), bus.rd_en, 1);
                chk($sformatf("b2b.rd_row t=%0d", t), bus.rd_row, (t - 1) % 2);
            end
            if (t == 2) chk("b2b.chain_ready", bus.cmd_ready, 1);
            if (t >= 5 && t <= 10) chk($sformatf("b2b.done t=%0d", t), bus.done, (t == 7 || t == 9));
            if (t == 9) chk("b2b.n_wait", bus.cmd_ready, 0);
            if (t == 10) chk("b2b.n_accept", bus.cmd_ready, 1);
            if (t == 16) chk("b2b.third_done", bus.done, 1);
            advance();
        end
`endif

        // Single-row block
        bus.cmd_valid = 1'b1; bus.cmd_n = 2'd2; bus.cmd_rows_m1 = 5'd0;
        for (int t = 0; t <= 8; t++) begin
            sample();
            chk($sformatf("one.rd_en t=%0d", t), bus.rd_en, (t == 1));
            if (t >= 5 && t <= 7) begin
                chk($sformatf("one.out_first t=%0d", t), bus.out_first, (t == 6));
                chk($sformatf("one.out_last t=%0d", t), bus.out_last, (t == 6));
                chk($sformatf("one.done t=%0d", t), bus.done, (t == 6));
            end
            if (t == 6 || t == 7) chk($sformatf("one.busy t=%0d", t), bus.busy, (t == 6));
            advance();
            bus.cmd_valid = 1'b0;
        end

        // Pop with no credit outstanding
        auto_pop = 1'b0;
        bus.out_pop = 1'b1;
        for (int t = 0; t <= 7; t++) begin
            if (t == 1) bus.out_pop = 1'b0;
            if (t == 6) rst = 1'b1;
            if (t == 7) rst = 1'b0;
            sample();
            if (t == 0) chk("ovf.pre_err", bus.cred_err, 0);
            if (t == 1) begin
                chk("ovf.err_set", bus.cred_err, 1);
                chk("ovf.credits", dut.r_credits, 4);
            end
            if (t == 5) chk("ovf.err_sticky", bus.cred_err, 1);
            if (t == 7) chk("ovf.err_cleared", bus.cred_err, 0);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
